wb_sram_responder: RTL and testbench

WB_SRAM_RESPONDER -- requirements
Module: wb_sram_responder

---
 rtl/kws_sram_pkg.sv | 22 ++
 rtl/sram_1024x32_array.sv | 29 ++
 rtl/wb_sram_responder.sv | 127 ++++++++++++
 tb/tb_wb_sram_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kws_sram_pkg.sv
// Shared definitions for the Wishbone weight-SRAM responder: default geometry,
// FSM state encoding and the value returned for out-of-range reads.
package kws_sram_pkg;

  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned AW_DEF    = 10;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_1024x32_array.sv
// Single-port synchronous weight SRAM: byte-write enables and a one-cycle
// registered read. Contents are never reset.
module sram_1024x32_array
  import kws_sram_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          en,
  input  logic          r_wb,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Storage port: registered read, or masked byte write.
  always_ff @(posedge clk) begin
    if (en && r_wb) begin
      rdata <= mem[addr];
    end else if (en) begin
      mem[addr] <= (mem[addr] & ~byte_mask(be)) | (wdata & byte_mask(be));
    end
  end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic responder in front of the weight SRAM: zero-fill after reset,
// one-cycle write ack, two-cycle read ack, out-of-range requests acked harmlessly.
module wb_sram_responder
  import kws_sram_pkg::*;
#(
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned AW             = AW_DEF,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        init_done_o
);

  localparam logic [AW-1:0] LAST_CLR = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   offset;
  logic          req, in_range, rd_in_range;
  logic          ack_q, init_done_q;
  logic [31:0]   dat_q;

  logic          mem_en, mem_rwb;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign offset   = wbs_adr_i - BASE_ADDR;
  assign in_range = (offset < 32'(DEPTH));

  // Outputs come from registers but are forced quiet for as long as reset is held.
  assign wbs_ack_o   = ack_q & ~wb_rst_i;
  assign wbs_dat_o   = dat_q & {32{~wb_rst_i}};
  assign init_done_o = CLEAR_ON_RESET ? (init_done_q & ~wb_rst_i) : 1'b1;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (clr_cnt == LAST_CLR) state_nxt = ST_IDLE;
        else                     state_nxt = ST_INIT;
      end
      ST_IDLE: begin
        if (req) state_nxt = wbs_we_i ? ST_ACK : ST_RD_WAIT;
        else     state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (wbs_cyc_i) state_nxt = ST_ACK;
        else           state_nxt = ST_IDLE;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SRAM port steering: zero-fill in INIT, otherwise in-range requests taken in IDLE.
  always_comb begin
    mem_en    = 1'b0;
    mem_rwb   = 1'b1;
    mem_be    = 4'h0;
    mem_addr  = offset[AW-1:0];
    mem_wdata = wbs_dat_i;
    if (wb_rst_i) begin
      mem_en = 1'b0;
    end else if (state == ST_INIT) begin
      mem_en    = 1'b1;
      mem_rwb   = 1'b0;
      mem_be    = 4'hF;
      mem_addr  = clr_cnt;
      mem_wdata = 32'h0000_0000;
    end else if ((state == ST_IDLE) && req && in_range) begin
      mem_en  = 1'b1;
      mem_rwb = ~wbs_we_i;
      mem_be  = wbs_we_i ? wbs_sel_i : 4'h0;
    end else begin
      mem_en = 1'b0;
    end
  end

  // State, clear counter and registered bus outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      clr_cnt     <= '0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0000_0000;
      init_done_q <= ~CLEAR_ON_RESET;
      rd_in_range <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state_nxt == ST_ACK);
      if (state == ST_INIT) clr_cnt <= clr_cnt + AW'(1);
      if ((state == ST_INIT) && (state_nxt == ST_IDLE)) init_done_q <= 1'b1;
      if (state == ST_IDLE) rd_in_range <= in_range;
      if ((state == ST_RD_WAIT) && (state_nxt == ST_ACK))
        dat_q <= rd_in_range ? mem_rdata : OOR_RDATA;
      else
        dat_q <= 32'h0000_0000;
    end
  end

  sram_1024x32_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (wb_clk_i),
    .en   (mem_en),
    .r_wb (mem_rwb),
    .be   (mem_be),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed self-checking bench for wb_sram_responder with default parameters.
module tb_wb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic        ack, init_done;
  logic [31:0] dat_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_mem [0:1023];

  always #5 clk = ~clk;

  wb_sram_responder dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .init_done_o(init_done)
  );

  // One transfer, started just after a rising edge; lat = edges until ack (0 = none).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic [31:0] rd,
                      output logic leak);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0; rd = 32'h0; leak = 1'b0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat = n; rd = dat_o; end
      else if (dat_o !== 32'h0) leak = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 32'd1024) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a[9:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) exp_mem[i] = 32'h0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 1100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 1024) begin
      failures++;
      $display("FAIL %s init_cycles: got %0d expected 1024", tag, n);
    end
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic leak;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b expected 0", ack); end
    checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat: got %h expected 00000000", dat_o); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    rst = 1'b0;
    wait_init("reset");
    model_clear();
    xfer(1'b0, 32'd5, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd5_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rd5_data: got %h expected 00000000", rd); end
  endtask

  task automatic test_init_holdoff();
    int lat, n; logic [31:0] rd; logic leak, done_at_ack;
    xfer(1'b1, 32'd9, 32'hDEAD_BEEF, 4'hF, lat, rd, leak);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr9_lat: got %0d expected 1", lat); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd9; sel = 4'hF;
    n = 0; lat = 0; done_at_ack = 1'b0;
    while (lat == 0 && n < 1100) begin
      @(posedge clk); #1; n++;
      if (ack) begin lat = n; rd = dat_o; done_at_ack = init_done; end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    model_clear();
    checks++; if (lat !== 1026) begin failures++; $display("FAIL holdoff_lat: got %0d expected 1026", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL holdoff_data: got %h expected 00000000", rd); end
    checks++; if (done_at_ack !== 1'b1) begin failures++; $display("FAIL holdoff_done: got %b expected 1", done_at_ack); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic leak;
    xfer(1'b1, 32'd20, 32'h0123_4567, 4'hF, lat, rd, leak);
    model_write(32'd20, 32'h0123_4567, 4'hF);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr20_lat: got %0d expected 1", lat); end
    xfer(1'b0, 32'd20, 32'h0, 4'h0, lat, rd, leak);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd20_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0123_4567) begin failures++; $display("FAIL rd20_data: got %h expected 01234567", rd); end
    checks++; if (leak !== 1'b0) begin failures++; $display("FAIL rd20_dat_without_ack: got %b expected 0", leak); end
    xfer(1'b1, 32'd21, 32'hA5A5_5A5A, 4'hF, lat, rd, leak);
    model_write(32'd21, 32'hA5A5_5A5A, 4'hF);
    xfer(1'b0, 32'd21, 32'h0, 4'h3, lat, rd, leak);
    checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL rd21_data: got %h expected a5a55a5a", rd); end
  endtask

  task automatic test_byte_sel();
    int lat; logic [31:0] rd; logic leak;
    xfer(1'b1, 32'd30, 32'h0123_4567, 4'hF, lat, rd, leak);
    xfer(1'b1, 32'd30, 32'hFFFF_FFFF, 4'b0101, lat, rd, leak);
    model_write(32'd30, 32'h0123_4567, 4'hF);
    model_write(32'd30, 32'hFFFF_FFFF, 4'b0101);
    checks++; if (lat !== 1) begin failures++; $display("FAIL sel5_lat: got %0d expected 1", lat); end
    xfer(1'b0, 32'd30, 32'h0, 4'h0, lat, rd, leak);
    checks++; if (rd !== 32'h01FF_45FF) begin failures++; $display("FAIL sel5_data: got %h expected 01ff45ff", rd); end
    xfer(1'b1, 32'd30, 32'hDEAD_BEEF, 4'b0000, lat, rd, leak);
    checks++; if (lat !== 1) begin failures++; $display("FAIL sel0_lat: got %0d expected 1", lat); end
    xfer(1'b0, 32'd30, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (rd !== 32'h01FF_45FF) begin failures++; $display("FAIL sel0_data: got %h expected 01ff45ff", rd); end
  endtask

  task automatic test_out_of_range();
    int lat, bad; logic [31:0] rd; logic leak, any_leak;
    xfer(1'b0, 32'd1024, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (lat !== 2) begin failures++; $display("FAIL oor_rd_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %h expected 00000000", rd); end
    xfer(1'b1, 32'd2000, 32'hFFFF_FFFF, 4'hF, lat, rd, leak);
    checks++; if (lat !== 1) begin failures++; $display("FAIL oor_wr_lat: got %0d expected 1", lat); end
    xfer(1'b1, 32'd1024, 32'hCAFE_F00D, 4'hF, lat, rd, leak);
    bad = 0; any_leak = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      xfer(1'b0, 32'(i), 32'h0, 4'hF, lat, rd, leak);
      any_leak |= leak;
      if (rd !== exp_mem[i] || lat !== 2) begin
        if (bad == 0) $display("FAIL sweep addr %0d: got %h lat %0d expected %h lat 2", i, rd, lat, exp_mem[i]);
        bad++;
      end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sweep_errors: got %0d expected 0", bad); end
    checks++; if (any_leak !== 1'b0) begin failures++; $display("FAIL sweep_dat_without_ack: got %b expected 0", any_leak); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic leak, seen;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd20; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ack) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_ack: got %b expected 0", seen); end
    xfer(1'b0, 32'd20, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (rd !== 32'h0123_4567) begin failures++; $display("FAIL abort_reread: got %h expected 01234567", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, idx, nack; int ack_cyc [2]; logic [31:0] rd; logic leak;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd22; dat_i = 32'h1111_2222; sel = 4'hF;
    idx = 0; nack = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        nack++;
        if (idx < 2) ack_cyc[idx] = c;
        idx++;
        if (idx == 1) begin adr = 32'd23; dat_i = 32'h3333_4444; end
        else begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
      end
    end
    model_write(32'd22, 32'h1111_2222, 4'hF);
    model_write(32'd23, 32'h3333_4444, 4'hF);
    checks++; if (ack_cyc[0] !== 1 || ack_cyc[1] !== 3)
      begin failures++; $display("FAIL b2b_ack_cycles: got %0d,%0d expected 1,3", ack_cyc[0], ack_cyc[1]); end
    checks++; if (nack !== 2) begin failures++; $display("FAIL b2b_ack_count: got %0d expected 2", nack); end
    xfer(1'b0, 32'd23, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (rd !== 32'h3333_4444) begin failures++; $display("FAIL b2b_rd23: got %h expected 33334444", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic leak;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd7; dat_i = 32'h7777_7777; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mid_rst_ack: got %b expected 0", ack); end
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_rst_init_restart: got %b expected 0", init_done); end
    wait_init("mid_reset");
    model_clear();
    xfer(1'b0, 32'd7, 32'h0, 4'hF, lat, rd, leak);
    checks++; if (rd !== 32'h0 || lat !== 2) begin failures++; $display("FAIL mid_rst_rd7: got %h lat %0d expected 00000000 lat 2", rd, lat); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_init_holdoff();
    test_write_read();
    test_abort();
    test_byte_sel();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
